// File: rtl/dp83848_link_poll.sv
// -----------------------------------------------------------------------------
// dp83848_link_poll
//
// MDIO station-management master. It periodically reads BMSR (register 0x01)
// of two DP83848 PHYs and publishes each PHY's link-status bit (BMSR[2]).
// Both link levels change together, in one clk, when a two-PHY round finishes.
//
// Ports
//   clk        : system clock
//   rst_n      : synchronous active-low reset
//   mdc        : management clock to both PHYs (clk / (2*MDC_DIV))
//   mdio_o     : MDIO output data
//   mdio_oe    : MDIO output enable (1 = drive mdio_o)
//   mdio_i     : MDIO input (pulled up externally, already synchronous to clk)
//   link1      : PHY 1 BMSR[2] from the last completed round
//   link2      : PHY 2 BMSR[2] from the last completed round
//   link_valid : one-clk pulse when link1/link2/mdio_err update
//   mdio_err   : bit0 = PHY 1 did not answer, bit1 = PHY 2 did not answer
// -----------------------------------------------------------------------------
module dp83848_link_poll #(
   parameter int unsigned MDC_DIV     = 25,
   parameter int unsigned POLL_CYCLES = 500000,
   parameter logic [4:0]  PHY1_ADDR   = 5'd1,
   parameter logic [4:0]  PHY2_ADDR   = 5'd2
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       mdc,
   output logic       mdio_o,
   output logic       mdio_oe,
   input  logic       mdio_i,
   output logic       link1,
   output logic       link2,
   output logic       link_valid,
   output logic [1:0] mdio_err
);

   localparam int unsigned DIV_W  = $clog2(MDC_DIV);
   localparam int unsigned POLL_W = $clog2(POLL_CYCLES + 1);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(MDC_DIV - 1);
   localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREAMBLE,
      S_HEADER,
      S_TA,
      S_DATA,
      S_NEXT,
      S_UPDATE
   } state_e;

   // Index of the last MDC period spent in each frame state.
   function automatic logic [4:0] period_last(input state_e s);
      case (s)
         S_PREAMBLE: return 5'd31;
         S_HEADER:   return 5'd13;
         S_TA:       return 5'd1;
         S_DATA:     return 5'd15;
         default:    return 5'd0;
      endcase
   endfunction

   state_e              state_q, state_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic                mdc_q, mdc_d;
   logic [4:0]          bit_q, bit_d;
   logic [POLL_W-1:0]   poll_q, poll_d;
   logic                phy_sel_q, phy_sel_d;
   logic                err_sel_q, err_sel_d;
   logic [15:0]         shift_q, shift_d;
   logic [1:0]          hold_link_q, hold_link_d;
   logic [1:0]          hold_err_q, hold_err_d;
   logic                mdio_o_q, mdio_o_d;
   logic                mdio_oe_q, mdio_oe_d;
   logic                link1_q, link1_d;
   logic                link2_q, link2_d;
   logic                link_valid_q, link_valid_d;
   logic [1:0]          mdio_err_q, mdio_err_d;

   // Divider terminal count; mdc toggles here. rise/fall name the mdc edge
   // that the registers will show after this clk.
   logic tick, rise, fall;
   assign tick = (div_q == DIV_LAST);
   assign rise = tick & ~mdc_q;
   assign fall = tick &  mdc_q;

   // ---------------------------------------------------------------------------
   // State register (reset is synchronous)
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: every flop uses <= so all registers update from the same
      // pre-edge values regardless of statement order.
      if (!rst_n) begin
         state_q      <= S_IDLE;
         div_q        <= '0;
         mdc_q        <= 1'b0;
         bit_q        <= '0;
         poll_q       <= '0;
         phy_sel_q    <= 1'b0;
         err_sel_q    <= 1'b0;
         shift_q      <= '0;
         hold_link_q  <= '0;
         hold_err_q   <= '0;
         mdio_o_q     <= 1'b1;
         mdio_oe_q    <= 1'b0;
         link1_q      <= 1'b0;
         link2_q      <= 1'b0;
         link_valid_q <= 1'b0;
         mdio_err_q   <= '0;
      end else begin
         state_q      <= state_d;
         div_q        <= div_d;
         mdc_q        <= mdc_d;
         bit_q        <= bit_d;
         poll_q       <= poll_d;
         phy_sel_q    <= phy_sel_d;
         err_sel_q    <= err_sel_d;
         shift_q      <= shift_d;
         hold_link_q  <= hold_link_d;
         hold_err_q   <= hold_err_d;
         mdio_o_q     <= mdio_o_d;
         mdio_oe_q    <= mdio_oe_d;
         link1_q      <= link1_d;
         link2_q      <= link2_d;
         link_valid_q <= link_valid_d;
         mdio_err_q   <= mdio_err_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic: sequencing, MDC divider, sampling and result capture
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      state_d     = state_q;
      div_d       = div_q;
      mdc_d       = mdc_q;
      bit_d       = bit_q;
      poll_d      = poll_q;
      phy_sel_d   = phy_sel_q;
      err_sel_d   = err_sel_q;
      shift_d     = shift_q;
      hold_link_d = hold_link_q;
      hold_err_d  = hold_err_q;

      case (state_q)
         S_IDLE: begin
            mdc_d = 1'b0;
            div_d = '0;
            bit_d = '0;
            if (poll_q == POLL_LAST) begin
               poll_d    = '0;
               phy_sel_d = 1'b0;
               err_sel_d = 1'b0;
               state_d   = S_PREAMBLE;
            end else begin
               poll_d = poll_q + 1'b1;
            end
         end

         S_UPDATE: begin
            div_d   = '0;
            poll_d  = '0;
            state_d = S_IDLE;
         end

         default: begin
            // Frame states: free-running divider, mdc toggles on terminal count.
            div_d = tick ? '0 : div_q + 1'b1;
            if (tick) mdc_d = ~mdc_q;

            // The PHY launches each bit after an MDC rising edge; it is taken
            // on the following rising edge.
            if (rise) begin
               if (state_q == S_TA && bit_q == 5'd1) err_sel_d = mdio_i;
               if (state_q == S_DATA)                shift_d   = {shift_q[14:0], mdio_i};
            end

            // Periods end on the mdc falling edge.
            if (fall) begin
               if (bit_q == period_last(state_q)) begin
                  bit_d = '0;
                  case (state_q)
                     S_PREAMBLE: state_d = S_HEADER;
                     S_HEADER:   state_d = S_TA;
                     S_TA:       state_d = S_DATA;
                     S_DATA:     state_d = S_NEXT;
                     default: begin
                        // End of NEXT: park this PHY's result until UPDATE.
                        hold_link_d[phy_sel_q] = shift_q[2] & ~err_sel_q;
                        hold_err_d[phy_sel_q]  = err_sel_q;
                        if (!phy_sel_q) begin
                           phy_sel_d = 1'b1;
                           err_sel_d = 1'b0;
                           state_d   = S_PREAMBLE;
                        end else begin
                           state_d = S_UPDATE;
                        end
                     end
                  endcase
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output logic. MDIO drive follows the next state, which only moves on an
   // mdc falling edge or at frame start, so data is stable across every rise.
   // ---------------------------------------------------------------------------
   logic [13:0] hdr;

   always_comb begin
      hdr = {4'b0110, (phy_sel_d ? PHY2_ADDR : PHY1_ADDR), 5'b00001};

      mdio_oe_d = (state_d == S_PREAMBLE) || (state_d == S_HEADER);
      mdio_o_d  = 1'b1;
      if (state_d == S_HEADER) mdio_o_d = hdr[4'd13 - bit_d[3:0]];

      link_valid_d = (state_q == S_UPDATE);
      link1_d      = link1_q;
      link2_d      = link2_q;
      mdio_err_d   = mdio_err_q;
      if (state_q == S_UPDATE) begin
         link1_d    = hold_link_q[0];
         link2_d    = hold_link_q[1];
         mdio_err_d = hold_err_q;
      end
   end

   assign mdc        = mdc_q;
   assign mdio_o     = mdio_o_q;
   assign mdio_oe    = mdio_oe_q;
   assign link1      = link1_q;
   assign link2      = link2_q;
   assign link_valid = link_valid_q;
   assign mdio_err   = mdio_err_q;

endmodule
